// File: rtl/ecc_mod_responder_pkg.sv
// Shared constants for the ECC modular-arithmetic responder: operand width,
// default prime, controller state encoding and request kinds.
package ecc_pkg;
  localparam int WIDTH = 64;
  localparam logic [63:0] P_DEFAULT = 64'd10997031918897188677;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RED  = 3'd1;
  localparam logic [2:0] ST_FIX  = 3'd2;
  localparam logic [2:0] ST_INV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  typedef enum logic {REQ_MOD = 1'b0, REQ_INV = 1'b1} req_t;
endpackage

// File: rtl/ecc_mod_responder_if.sv
// Request/response bundle between the point add/double controller (master)
// and the modular-arithmetic responder (slave).
interface ecc_mod_responder_if #(parameter int WIDTH = 64);
  logic             helpmod;
  logic [WIDTH-1:0] mod_a;
  logic             neg_mod_a;
  logic             moddone;
  logic [WIDTH-1:0] mod_result;
  logic             helpinvmod;
  logic [WIDTH-1:0] invmod_a;
  logic             neg_invmod_a;
  logic             invmoddone;
  logic [WIDTH-1:0] invmod_result;
  logic             invmod_err;
  logic             busy;

  modport master (
    output helpmod, mod_a, neg_mod_a, helpinvmod, invmod_a, neg_invmod_a,
    input  moddone, mod_result, invmoddone, invmod_result, invmod_err, busy
  );

  modport slave (
    input  helpmod, mod_a, neg_mod_a, helpinvmod, invmod_a, neg_invmod_a,
    output moddone, mod_result, invmoddone, invmod_result, invmod_err, busy
  );
endinterface

// File: rtl/ecc_mod_responder_reduce.sv
// Bit-serial restoring reduction of a signed-magnitude operand into [0,P):
// MSB first, one bit per cycle; r presents the sign-corrected residue.
module mod_shift_reduce #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] P     = ecc_pkg::P_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] r,
  output logic             valid
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] P_EXT = {1'b0, P};

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] acc_q;
  logic             neg_q;
  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   trial;

  // 2r + bit is below 2P, so a single conditional subtract restores the range.
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0] t);
    return WIDTH'((t >= P_EXT) ? (t - P_EXT) : t);
  endfunction

  assign trial = {acc_q, a_q[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      valid <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      valid <= 1'b0;
      cnt_q <= CNT_W'(1);
    end else if (run_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        run_q <= 1'b0;
        valid <= 1'b1;
      end
    end
  end

  // The MSB step is folded into the start cycle (0*2 + bit is always < P).
  always_ff @(posedge clk) begin
    if (start) begin
      acc_q <= {{(WIDTH-1){1'b0}}, a[WIDTH-1]};
      a_q   <= a << 1;
      neg_q <= neg;
    end else if (run_q) begin
      acc_q <= cond_sub(trial);
      a_q   <= a_q << 1;
    end
  end

  assign r = (neg_q && (acc_q != '0)) ? (P - acc_q) : acc_q;
endmodule

// File: rtl/ecc_mod_responder.sv
// Responder for the helpmod/moddone and helpinvmod/invmoddone handshakes:
// serial reduction followed, for inverses, by a binary extended Euclid.
module ecc_mod_responder #(
  parameter int               WIDTH = ecc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] P     = ecc_pkg::P_DEFAULT
) (
  input logic clk,
  input logic rst,
  ecc_mod_responder_if.slave bus
);
  import ecc_pkg::*;

  localparam logic [WIDTH:0] P_EXT = {1'b0, P};
  localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

  logic [2:0]       state_q;
  req_t             kind_q;
  logic             start;
  logic             line;
  logic [WIDTH-1:0] a_sel;
  logic             neg_sel;
  logic [WIDTH-1:0] red_r;
  logic             red_valid;
  logic [WIDTH:0]   u_q, v_q, x1_q, x2_q;
  logic [WIDTH:0]   u_n, v_n, x1_n, x2_n;
  logic             inv_exit;
  logic [WIDTH-1:0] inv_res;
  logic [WIDTH-1:0] res_q;
  logic             err_q;

  function automatic logic [WIDTH:0] half_mod(input logic [WIDTH:0] x);
    return x[0] ? ((x + P_EXT) >> 1) : (x >> 1);
  endfunction

  function automatic logic [WIDTH:0] sub_mod(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    return (a >= b) ? (a - b) : (a + P_EXT - b);
  endfunction

  // Reduction wins when both lines are up; the inverse waits for the next IDLE.
  assign start   = (state_q == ST_IDLE) && (bus.helpmod || bus.helpinvmod);
  assign a_sel   = bus.helpmod ? bus.mod_a : bus.invmod_a;
  assign neg_sel = bus.helpmod ? bus.neg_mod_a : bus.neg_invmod_a;
  assign line    = (kind_q == REQ_MOD) ? bus.helpmod : bus.helpinvmod;
  assign bus.busy = (state_q != ST_IDLE);

  mod_shift_reduce #(.WIDTH(WIDTH), .P(P)) u_reduce (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_sel),
    .neg   (neg_sel),
    .r     (red_r),
    .valid (red_valid)
  );

  // Invariants: x1*r == u and x2*r == v (mod P).
  always_comb begin
    u_n  = u_q;
    v_n  = v_q;
    x1_n = x1_q;
    x2_n = x2_q;
    if (!u_q[0]) begin
      u_n  = u_q >> 1;
      x1_n = half_mod(x1_q);
    end else if (!v_q[0]) begin
      v_n  = v_q >> 1;
      x2_n = half_mod(x2_q);
    end else if (u_q >= v_q) begin
      u_n  = u_q - v_q;
      x1_n = sub_mod(x1_q, x2_q);
    end else begin
      v_n  = v_q - u_q;
      x2_n = sub_mod(x2_q, x1_q);
    end
  end

  // Exit on the current values (only hit when r==1) or on the step just taken.
  always_comb begin
    inv_exit = (u_q == ONE) || (v_q == ONE) || (u_n == ONE) || (v_n == ONE);
    if (u_q == ONE)      inv_res = WIDTH'(x1_q);
    else if (v_q == ONE) inv_res = WIDTH'(x2_q);
    else if (u_n == ONE) inv_res = WIDTH'(x1_n);
    else                 inv_res = WIDTH'(x2_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      kind_q            <= REQ_MOD;
      bus.moddone       <= 1'b0;
      bus.invmoddone    <= 1'b0;
      bus.mod_result    <= '0;
      bus.invmod_result <= '0;
      bus.invmod_err    <= 1'b0;
    end else begin
      bus.moddone    <= 1'b0;
      bus.invmoddone <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RED;
          kind_q  <= bus.helpmod ? REQ_MOD : REQ_INV;
        end
        ST_RED:  if (red_valid) state_q <= ST_FIX;
        ST_FIX:  state_q <= ((kind_q == REQ_MOD) || (red_r == '0)) ? ST_DONE : ST_INV;
        ST_INV:  if (inv_exit) state_q <= ST_DONE;
        ST_DONE: begin
          if (kind_q == REQ_MOD) begin
            bus.moddone    <= 1'b1;
            bus.mod_result <= res_q;
          end else begin
            bus.invmoddone    <= 1'b1;
            bus.invmod_result <= res_q;
            bus.invmod_err    <= err_q;
          end
          state_q <= ST_HOLD;
        end
        // One done per request: wait for the served line to drop.
        ST_HOLD: if (!line) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIX stage / INV stage datapath
  always_ff @(posedge clk) begin
    case (state_q)
      ST_FIX: begin
        u_q   <= {1'b0, red_r};
        v_q   <= P_EXT;
        x1_q  <= ONE;
        x2_q  <= '0;
        res_q <= red_r;
        err_q <= (kind_q == REQ_INV) && (red_r == '0);
      end
      ST_INV: begin
        u_q   <= u_n;
        v_q   <= v_n;
        x1_q  <= x1_n;
        x2_q  <= x2_n;
        res_q <= inv_res;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ecc_mod_responder.sv
// Self-checking bench for ecc_mod_responder: directed cases plus a randomized
// sweep against an arithmetic reference (remainder and brute-force inverse).
module tb_ecc_mod_responder;
  localparam logic [63:0] PS = 64'd97;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  ecc_mod_responder_if #(.WIDTH(64)) bi ();
  ecc_mod_responder_if #(.WIDTH(64)) bb ();

  ecc_mod_responder #(.WIDTH(64), .P(PS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  ecc_mod_responder #(.WIDTH(64), .P(64'd10997031918897188677)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_red(input logic [63:0] a, input bit neg);
    logic [63:0] r;
    r = a % PS;
    if (neg && r != 64'd0) r = PS - r;
    return r;
  endfunction

  function automatic logic [63:0] ref_inv(input logic [63:0] r);
    for (int x = 1; x < 97; x++)
      if (((r * 64'(x)) % PS) == 64'd1) return 64'(x);
    return 64'd0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((bi.busy !== 1'b0 || bb.busy !== 1'b0) && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // Called just after the accept edge; lat counts edges until the done pulse.
  task automatic wait_done(input bit big, input bit inv, output logic [63:0] res,
                           output logic err, output int lat, output bit both);
    bit got = 1'b0;
    lat = 0; both = 1'b0; res = '0; err = 1'b0;
    while (!got && lat < 400) begin
      @(posedge clk); #1; lat++;
      if (big) begin
        if (bb.moddone === 1'b1) begin got = 1'b1; res = bb.mod_result; end
      end else begin
        if (bi.moddone === 1'b1 && bi.invmoddone === 1'b1) both = 1'b1;
        if ((inv ? bi.invmoddone : bi.moddone) === 1'b1) begin
          got = 1'b1;
          res = inv ? bi.invmod_result : bi.mod_result;
          err = bi.invmod_err;
        end
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic req_small(input bit inv, input logic [63:0] a, input bit neg,
                           output logic [63:0] res, output logic err, output int lat,
                           output bit extra);
    bit both;
    wait_idle();
    @(negedge clk);
    if (inv) begin bi.invmod_a = a; bi.neg_invmod_a = neg; bi.helpinvmod = 1'b1; end
    else     begin bi.mod_a = a;    bi.neg_mod_a = neg;    bi.helpmod = 1'b1;    end
    @(posedge clk); #1;
    bi.mod_a = {$urandom, $urandom};
    bi.invmod_a = {$urandom, $urandom};
    bi.neg_mod_a = 1'($urandom);
    bi.neg_invmod_a = 1'($urandom);
    wait_done(1'b0, inv, res, err, lat, both);
    @(posedge clk); #1;
    extra = both | (bi.moddone === 1'b1) | (bi.invmoddone === 1'b1);
    @(negedge clk);
    bi.helpmod = 1'b0;
    bi.helpinvmod = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bi.moddone !== 1'b0) begin bad++; $display("FAIL reset_moddone: got %b want 0", bi.moddone); end
    total++; if (bi.invmoddone !== 1'b0) begin bad++; $display("FAIL reset_invmoddone: got %b want 0", bi.invmoddone); end
    total++; if (bi.mod_result !== 64'd0) begin bad++; $display("FAIL reset_mod_result: got %0d want 0", bi.mod_result); end
    total++; if (bi.invmod_result !== 64'd0) begin bad++; $display("FAIL reset_invmod_result: got %0d want 0", bi.invmod_result); end
    total++; if (bi.invmod_err !== 1'b0) begin bad++; $display("FAIL reset_invmod_err: got %b want 0", bi.invmod_err); end
    total++; if (bi.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bi.busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mod_basic();
    logic [63:0] ta [3];
    bit          tn [3];
    logic [63:0] te [3];
    logic [63:0] res; logic err; int lat; bit extra;
    ta = '{64'd970, 64'd1000, 64'd1000};
    tn = '{1'b1, 1'b1, 1'b0};
    te = '{64'd0, 64'd67, 64'd30};
    for (int i = 0; i < 3; i++) begin
      req_small(1'b0, ta[i], tn[i], res, err, lat, extra);
      total++; if (res !== te[i]) begin bad++; $display("FAIL mod_result[%0d]: got %0d want %0d", i, res, te[i]); end
      total++; if (lat != 66) begin bad++; $display("FAIL mod_latency[%0d]: got %0d want 66", i, lat); end
      total++; if (extra) begin bad++; $display("FAIL mod_pulse_width[%0d]: got extra pulse want none", i); end
    end
  endtask

  task automatic test_inv_basic();
    logic [63:0] ta [3];
    bit          tn [3];
    logic [63:0] te [3];
    logic        tr [3];
    logic [63:0] res; logic err; int lat; bit extra;
    ta = '{64'd3, 64'd3, 64'd194};
    tn = '{1'b0, 1'b1, 1'b0};
    te = '{64'd65, 64'd32, 64'd0};
    tr = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      req_small(1'b1, ta[i], tn[i], res, err, lat, extra);
      total++; if (res !== te[i]) begin bad++; $display("FAIL inv_result[%0d]: got %0d want %0d", i, res, te[i]); end
      total++; if (err !== tr[i]) begin bad++; $display("FAIL inv_err[%0d]: got %b want %b", i, err, tr[i]); end
      total++;
      if (tr[i] ? (lat != 66) : (lat < 67 || lat > 196)) begin
        bad++; $display("FAIL inv_latency[%0d]: got %0d want %s", i, lat, tr[i] ? "66" : "67..196");
      end
      total++; if (extra) begin bad++; $display("FAIL inv_pulse_width[%0d]: got extra pulse want none", i); end
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    logic [63:0] res; logic err; int lat; bit both;
    wait_idle();
    @(negedge clk);
    bi.mod_a = 64'd1000; bi.neg_mod_a = 1'b0; bi.helpmod = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; bi.helpmod = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bi.moddone === 1'b1) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", cnt); end
    total++; if (bi.mod_result !== 64'd0) begin bad++; $display("FAIL rstmid_mod_result: got %0d want 0", bi.mod_result); end
    total++; if (bi.invmod_err !== 1'b0) begin bad++; $display("FAIL rstmid_invmod_err: got %b want 0", bi.invmod_err); end
    total++; if (bi.invmod_result !== 64'd0) begin bad++; $display("FAIL rstmid_invmod_result: got %0d want 0", bi.invmod_result); end
    total++; if (bi.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bi.busy); end
    // A request already waiting is accepted on the first edge after rst drops.
    @(negedge clk);
    rst = 1'b1; bi.mod_a = 64'd1000; bi.neg_mod_a = 1'b0; bi.helpmod = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wait_done(1'b0, 1'b0, res, err, lat, both);
    total++; if (lat != 66) begin bad++; $display("FAIL rstmid_accept_latency: got %0d want 66", lat); end
    total++; if (res !== 64'd30) begin bad++; $display("FAIL rstmid_accept_result: got %0d want 30", res); end
    @(negedge clk);
    bi.helpmod = 1'b0;
  endtask

  task automatic test_big();
    logic [63:0] res; logic err; int lat; bit both;
    wait_idle();
    @(negedge clk);
    bb.mod_a = 64'hFFFF_FFFF_FFFF_FFFF; bb.neg_mod_a = 1'b0; bb.helpmod = 1'b1;
    @(posedge clk); #1;
    bb.mod_a = 64'd5;
    wait_done(1'b1, 1'b0, res, err, lat, both);
    total++; if (res !== 64'd7449712154812362938) begin bad++; $display("FAIL big_result: got %0d want 7449712154812362938", res); end
    total++; if (lat != 66) begin bad++; $display("FAIL big_latency: got %0d want 66", lat); end
    @(negedge clk);
    bb.helpmod = 1'b0;
  endtask

  task automatic test_both();
    int mc = 0;
    int ic = 0;
    bit both_any = 1'b0;
    logic [63:0] res; logic err; int lat; bit both;
    wait_idle();
    @(negedge clk);
    bi.mod_a = 64'd1000; bi.neg_mod_a = 1'b0;
    bi.invmod_a = 64'd3; bi.neg_invmod_a = 1'b0;
    bi.helpmod = 1'b1; bi.helpinvmod = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bi.moddone === 1'b1) mc++;
      if (bi.invmoddone === 1'b1) ic++;
      if (bi.moddone === 1'b1 && bi.invmoddone === 1'b1) both_any = 1'b1;
    end
    total++; if (mc != 1) begin bad++; $display("FAIL both_moddone_count: got %0d want 1", mc); end
    total++; if (ic != 0) begin bad++; $display("FAIL both_inv_waits: got %0d pulses want 0", ic); end
    total++; if (bi.mod_result !== 64'd30) begin bad++; $display("FAIL both_mod_result: got %0d want 30", bi.mod_result); end
    @(negedge clk);
    bi.helpmod = 1'b0;
    wait_done(1'b0, 1'b1, res, err, lat, both);
    both_any |= both;
    total++; if (lat < 1) begin bad++; $display("FAIL both_inv_done: got timeout want pulse"); end
    total++; if (res !== 64'd65 || err !== 1'b0) begin bad++; $display("FAIL both_inv_result: got %0d err %b want 65 err 0", res, err); end
    total++; if (both_any) begin bad++; $display("FAIL both_same_cycle: got simultaneous dones want none"); end
    @(negedge clk);
    bi.helpinvmod = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] a, r, want, res;
    logic err; int lat; bit extra, inv, neg;
    for (int n = 0; n < 500; n++) begin
      inv = 1'($urandom);
      neg = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = PS * 64'($urandom_range(0, 5000));
        1:       a = 64'($urandom_range(0, 300));
        default: a = {$urandom, $urandom};
      endcase
      r = ref_red(a, neg);
      req_small(inv, a, neg, res, err, lat, extra);
      total++; if (extra) begin bad++; $display("FAIL rnd_pulse[%0d]: got extra pulse want none", n); end
      if (!inv) begin
        total++; if (res !== r) begin bad++; $display("FAIL rnd_mod[%0d]: a=%0d neg=%0d got %0d want %0d", n, a, neg, res, r); end
        total++; if (lat != 66) begin bad++; $display("FAIL rnd_mod_lat[%0d]: got %0d want 66", n, lat); end
      end else if (r == 64'd0) begin
        total++; if (res !== 64'd0 || err !== 1'b1) begin bad++; $display("FAIL rnd_inv_err[%0d]: got %0d err %b want 0 err 1", n, res, err); end
        total++; if (lat != 66) begin bad++; $display("FAIL rnd_inv_err_lat[%0d]: got %0d want 66", n, lat); end
      end else begin
        want = ref_inv(r);
        total++; if (res !== want || err !== 1'b0) begin bad++; $display("FAIL rnd_inv[%0d]: r=%0d got %0d err %b want %0d err 0", n, r, res, err, want); end
        total++; if (((r * res) % PS) !== 64'd1) begin bad++; $display("FAIL rnd_inv_prod[%0d]: got %0d want 1", n, (r * res) % PS); end
        total++; if (lat < 67 || lat > 196) begin bad++; $display("FAIL rnd_inv_lat[%0d]: got %0d want 67..196", n, lat); end
      end
    end
  endtask

  initial begin
    bi.helpmod = 1'b0; bi.mod_a = '0; bi.neg_mod_a = 1'b0;
    bi.helpinvmod = 1'b0; bi.invmod_a = '0; bi.neg_invmod_a = 1'b0;
    bb.helpmod = 1'b0; bb.mod_a = '0; bb.neg_mod_a = 1'b0;
    bb.helpinvmod = 1'b0; bb.invmod_a = '0; bb.neg_invmod_a = 1'b0;
    test_reset();
    test_mod_basic();
    test_inv_basic();
    test_reset_mid();
    test_big();
    test_both();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
